cornice_mobile: RTL and testbench

- Parametrised moving rectangle/frame generator for the raster display path.
- Holds its own top-left position and updates it once per frame: X wraps around the screen edges, Y bounces at the top and bottom.
- Answers per-pixel hit queries through a 2-stage pipeline, with modes: off / filled / frame / blinking frame.
- Sits between the raster coordinate generator and the colour mux, one instance per on-screen object.

---
 rtl/cornice_mobile.sv | 146 ++++++++++++++
 tb/tb_cornice_mobile.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cornice_mobile.sv
// Moving rectangle/frame object: per-frame position update (X wraps, Y bounces)
// and a 2-stage pipelined per-pixel hit test with off/filled/frame/blink modes.
module cornice_mobile #(
  parameter int unsigned W         = 11,
  parameter int unsigned H         = 1280,
  parameter int unsigned V         = 1024,
  parameter int unsigned LARGHEZZA = 100,
  parameter int unsigned ALTEZZA   = 100,
  parameter int unsigned SPESSORE  = 6,
  parameter int unsigned X_INIT    = 100,
  parameter int unsigned Y_INIT    = 100,
  parameter int unsigned LAMP_LOG2 = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         FRAME_START,
  input  logic         MUOVI,
  input  logic [4:0]   VX,
  input  logic [3:0]   VY,
  input  logic [1:0]   MODO,
  input  logic         PIXEL_VALID,
  input  logic [W-1:0] X_CONTROLLO,
  input  logic [W-1:0] Y_CONTROLLO,
  output logic         VALID_OUT,
  output logic         CONFERMA,
  output logic         ESTERNO,
  output logic         INTERNO,
  output logic [W-1:0] X_POS,
  output logic [W-1:0] Y_POS,
  output logic         RIMBALZO
);

  // Two guard bits so the X/Y sums can go negative or past the screen edge.
  localparam int unsigned SW    = W + 2;
  localparam logic [W-1:0] Y_MAX = W'(V - ALTEZZA);

  logic [W-1:0]         x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic                 dir_up_q, dir_up_d, rimbalzo_q, rimbalzo_d;
  logic [LAMP_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic                 blink_vis_q, blink_vis_d;
  logic [SW-1:0]        s_c, t_c;

  logic                 v1_q, flag_q, flag_d;
  logic [W-1:0]         dx_q, dx_d, dy_q, dy_d;
  logic                 v2_q, conf_q, est_q, int_q;
  logic                 conf_d, est_d, int_d, frame_d;

  // Per-frame position, bounce direction and blink phase
  always_comb begin
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    dir_up_d    = dir_up_q;
    rimbalzo_d  = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    s_c = {2'b00, x_pos_q} + {{(SW-5){VX[4]}}, VX};
    t_c = dir_up_q ? ({2'b00, y_pos_q} - SW'(VY)) : ({2'b00, y_pos_q} + SW'(VY));
    if (FRAME_START && MUOVI) begin
      if (s_c[SW-1])          x_pos_d = W'(s_c + SW'(H));
      else if (s_c >= SW'(H)) x_pos_d = W'(s_c - SW'(H));
      else                    x_pos_d = W'(s_c);
      if (!dir_up_q && (t_c > SW'(Y_MAX))) begin
        y_pos_d    = Y_MAX;
        dir_up_d   = 1'b1;
        rimbalzo_d = 1'b1;
      end else if (dir_up_q && t_c[SW-1]) begin
        y_pos_d    = '0;
        dir_up_d   = 1'b0;
        rimbalzo_d = 1'b1;
      end else begin
        y_pos_d = W'(t_c);
      end
    end
    if (FRAME_START) begin
      blink_cnt_d = blink_cnt_q + LAMP_LOG2'(1);
      if (&blink_cnt_q) blink_vis_d = !blink_vis_q;
    end
  end

  // Stage 1: offsets relative to the current top-left, with horizontal wrap
  always_comb begin
    dx_d = X_CONTROLLO - x_pos_q;
    if (X_CONTROLLO < x_pos_q) dx_d = dx_d + W'(H);
    dy_d   = Y_CONTROLLO - y_pos_q;
    flag_d = (X_CONTROLLO >= W'(H)) || (Y_CONTROLLO >= W'(V)) || (Y_CONTROLLO < y_pos_q);
  end

  // Stage 2: rectangle tests and mode select
  always_comb begin
    est_d   = v1_q && !flag_q && (dx_q < W'(LARGHEZZA)) && (dy_q < W'(ALTEZZA));
    int_d   = est_d
              && (dx_q >= W'(SPESSORE)) && (dx_q < W'(LARGHEZZA - SPESSORE))
              && (dy_q >= W'(SPESSORE)) && (dy_q < W'(ALTEZZA - SPESSORE));
    frame_d = est_d && !int_d;
    conf_d  = 1'b0;
    case (MODO)
      2'd0:    conf_d = 1'b0;
      2'd1:    conf_d = est_d;
      2'd2:    conf_d = frame_d;
      default: conf_d = frame_d && blink_vis_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_pos_q     <= W'(X_INIT);
      y_pos_q     <= W'(Y_INIT);
      dir_up_q    <= 1'b0;
      rimbalzo_q  <= 1'b0;
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
      v1_q        <= 1'b0;
      flag_q      <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      v2_q        <= 1'b0;
      conf_q      <= 1'b0;
      est_q       <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      dir_up_q    <= dir_up_d;
      rimbalzo_q  <= rimbalzo_d;
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
      v1_q        <= PIXEL_VALID;
      flag_q      <= flag_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      v2_q        <= v1_q;
      conf_q      <= conf_d;
      est_q       <= est_d;
      int_q       <= int_d;
    end
  end

  assign VALID_OUT = v2_q;
  assign CONFERMA  = conf_q;
  assign ESTERNO   = est_q;
  assign INTERNO   = int_q;
  assign X_POS     = x_pos_q;
  assign Y_POS     = y_pos_q;
  assign RIMBALZO  = rimbalzo_q;

endmodule

// File: tb/tb_cornice_mobile.sv
// Randomised bench for cornice_mobile against an arithmetic reference model.
module tb_cornice_mobile;

  localparam int W = 11, H = 1280, V = 1024, L = 100, A = 100, S = 6;
  localparam int XI = 100, YI = 100, LL = 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         FRAME_START = 1'b0, MUOVI = 1'b0;
  logic [4:0]   VX = '0;
  logic [3:0]   VY = '0;
  logic [1:0]   MODO = '0;
  logic         PIXEL_VALID = 1'b0;
  logic [W-1:0] X_CONTROLLO = '0, Y_CONTROLLO = '0;
  logic         VALID_OUT, CONFERMA, ESTERNO, INTERNO, RIMBALZO;
  logic [W-1:0] X_POS, Y_POS;

  cornice_mobile #(
    .W(W), .H(H), .V(V), .LARGHEZZA(L), .ALTEZZA(A), .SPESSORE(S),
    .X_INIT(XI), .Y_INIT(YI), .LAMP_LOG2(LL)
  ) dut (
    .CLK(CLK), .RST(RST), .FRAME_START(FRAME_START), .MUOVI(MUOVI),
    .VX(VX), .VY(VY), .MODO(MODO), .PIXEL_VALID(PIXEL_VALID),
    .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
    .VALID_OUT(VALID_OUT), .CONFERMA(CONFERMA), .ESTERNO(ESTERNO), .INTERNO(INTERNO),
    .X_POS(X_POS), .Y_POS(Y_POS), .RIMBALZO(RIMBALZO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_x, m_y, m_frames;
  bit m_down, m_rimb;
  bit p_v, p_e, p_i;
  bit o_v, o_c, o_e, o_i;

  task automatic model_reset();
    m_x = XI; m_y = YI; m_frames = 0; m_down = 1; m_rimb = 0;
    p_v = 0; p_e = 0; p_i = 0;
    o_v = 0; o_c = 0; o_e = 0; o_i = 0;
  endtask

  function automatic void geom(input int x, input int y, input int px, input int py,
                               output bit e, output bit i);
    int dx, dy;
    dx = x - px;
    if (dx < 0) dx += H;
    dy = y - py;
    e = (x < H) && (y < V) && (y >= py) && (dx < L) && (dy < A);
    i = e && (dx >= S) && (dx < L - S) && (dy >= S) && (dy < A - S);
  endfunction

  // One clock edge of the intended behaviour, using the inputs as currently driven.
  task automatic model_step();
    bit vis, ne, ni;
    int vx, s, t;
    vis = ((m_frames >> LL) % 2) == 0;
    o_v = p_v;
    o_e = p_v && p_e;
    o_i = p_v && p_i;
    case (MODO)
      2'd0:    o_c = 0;
      2'd1:    o_c = p_v && p_e;
      2'd2:    o_c = p_v && p_e && !p_i;
      default: o_c = p_v && p_e && !p_i && vis;
    endcase
    geom(int'(X_CONTROLLO), int'(Y_CONTROLLO), m_x, m_y, ne, ni);
    p_v = PIXEL_VALID; p_e = ne; p_i = ni;
    m_rimb = 0;
    if (FRAME_START) begin
      m_frames++;
      if (MUOVI) begin
        vx = VX[4] ? int'(VX) - 32 : int'(VX);
        s = m_x + vx;
        if (s >= H) s -= H;
        else if (s < 0) s += H;
        m_x = s;
        if (m_down) begin
          t = m_y + int'(VY);
          if (t > V - A) begin m_y = V - A; m_down = 0; m_rimb = 1; end
          else m_y = t;
        end else begin
          t = m_y - int'(VY);
          if (t < 0) begin m_y = 0; m_down = 1; m_rimb = 1; end
          else m_y = t;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("valid_out", VALID_OUT, o_v);
    check_eq("conferma", CONFERMA, o_c);
    check_eq("esterno", ESTERNO, o_e);
    check_eq("interno", INTERNO, o_i);
    check_eq("x_pos", X_POS, m_x);
    check_eq("y_pos", Y_POS, m_y);
    check_eq("rimbalzo", RIMBALZO, m_rimb);
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic query(input int x, input int y, input int m, input bit fs);
    PIXEL_VALID = 1; X_CONTROLLO = W'(x); Y_CONTROLLO = W'(y);
    MODO = 2'(m); FRAME_START = fs;
    tick();
  endtask

  // Asynchronous reset asserted away from the clock edge with a query in flight.
  task automatic async_reset();
    query(XI, YI + 50, 1, 0);
    PIXEL_VALID = 1;
    @(posedge CLK);
    model_step();
    #2 RST = 1;
    #1;
    model_reset();
    check_eq("rst_x_pos", X_POS, XI);
    check_eq("rst_y_pos", Y_POS, YI);
    check_eq("rst_valid", VALID_OUT, 0);
    check_eq("rst_conferma", CONFERMA, 0);
    @(negedge CLK);
    check_all();
    PIXEL_VALID = 0; FRAME_START = 0; MUOVI = 0;
    @(negedge CLK);
    RST = 0;
  endtask

  int xs[8] = '{100, 199, 200, 99, 105, 106, 193, 194};
  int ys[8] = '{100, 199, 150, 150, 150, 150, 150, 150};
  int ms[8] = '{1, 1, 1, 1, 2, 2, 2, 2};

  initial begin
    int seg_vx, x, y;
    model_reset();
    #2 RST = 1;
    #1;
    check_all();
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;

    // Directed geometry at the reset position, back-to-back
    for (int i = 0; i < 8; i++) query(xs[i], ys[i], ms[i], 0);
    PIXEL_VALID = 0;
    tick(); tick();

    // Blink on a border pixel with position frozen
    MUOVI = 0;
    for (int f = 0; f < 6; f++) begin
      query(XI, YI + 50, 3, 1);
      query(XI, YI + 50, 3, 0);
      query(XI, YI + 50, 3, 0);
    end
    async_reset();
    for (int f = 0; f < 3; f++) begin
      query(XI, YI + 50, 3, 1);
      query(XI, YI + 50, 3, 0);
      query(XI, YI + 50, 3, 0);
    end

    // Randomised run
    seg_vx = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) seg_vx = $urandom_range(0, 31);
      if (c == 2000) async_reset();
      FRAME_START = ($urandom_range(0, 3) == 0);
      MUOVI       = ($urandom_range(0, 3) != 0);
      VX          = 5'(seg_vx);
      VY          = 4'($urandom_range(0, 15));
      MODO        = 2'($urandom_range(0, 3));
      PIXEL_VALID = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        x = $urandom_range(0, 2047);
        y = $urandom_range(0, 2047);
      end else begin
        x = (m_x + $urandom_range(0, 119) + H - 10) % H;
        y = m_y + $urandom_range(0, 119) - 10;
        if (y < 0) y = 0;
      end
      X_CONTROLLO = W'(x);
      Y_CONTROLLO = W'(y);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
